// File: rtl/ela_pkg.sv
// Shared definitions for the ELA result-frame memory arbiter: widths, frame
// geometry, arbitration state encoding and watermark defaults.
package ela_pkg;

   localparam int AW_DEF    = 13;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 8;
   localparam int HI_WM_DEF = 6;

   localparam int WIDTH        = 128;
   localparam int HEIGHT       = 63;
   localparam int FRAME_PIXELS = WIDTH * HEIGHT;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      READ    = 2'd2,
      RD_WAIT = 2'd3
   } arb_state_t;

endpackage

// File: rtl/ela_wr_fifo.sv
// Write-absorbing FIFO for the ELA pixel stream, with a parallel address
// match across all occupied entries for the read-after-write hazard check.
module ela_wr_fifo
   import ela_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [AW-1:0]              push_addr,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [AW-1:0]              head_addr,
   output logic [DW-1:0]              head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   input  logic [AW-1:0]              cmp_addr,
   output logic                       hit
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic          full;
   logic          do_push;
   logic          do_pop;
   logic [DEPTH-1:0] match;

   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   // A push at full is only accepted when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   assign head_addr = addr_mem[rd_ptr_reg];
   assign head_data = data_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr_reg] <= push_addr;
         data_mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count      <= '0;
         ovf        <= 1'b0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push && !do_push) ovf <= 1'b1;
      end
   end

   // Entry gi is occupied when its distance from the head is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] ofs;
      assign ofs       = PW'(gi) - rd_ptr_reg;
      assign match[gi] = ({1'b0, ofs} < count) && (addr_mem[gi] == cmp_addr);
   end

   assign hit = |match;

endmodule

// File: rtl/ela_mem_arbiter.sv
// Shares the single-port result frame memory between the buffered ELA write
// stream and host readback, preserving read-after-write order per address.
module ela_mem_arbiter
   import ela_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int HI_WM = HI_WM_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          frame_done,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ack,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          mem_ce,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          ovf,
   output logic          flushed,
   output logic          busy
);

   localparam int CW = $clog2(DEPTH) + 1;

   arb_state_t    state_reg;
   logic [CW-1:0] fifo_count;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          fifo_hit;
   logic          raw_hit;
   logic          rd_inflight;
   logic          grant_rd;
   logic          grant_wr;
   logic [DW-1:0] rd_data_reg;

   ela_wr_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_addr (wr_addr),
      .push_data (wr_data),
      .pop       (grant_wr),
      .head_addr (head_addr),
      .head_data (head_data),
      .count     (fifo_count),
      .ovf       (ovf),
      .cmp_addr  (rd_addr),
      .hit       (fifo_hit)
   );

   // The entry being pushed this cycle is not yet in storage but must still
   // block a read of the same address.
   assign raw_hit     = fifo_hit || (wr_en && (wr_addr == rd_addr));
   assign rd_inflight = (state_reg == READ) || (state_reg == RD_WAIT);
   assign grant_rd    = rd_req && !rd_inflight && (fifo_count < CW'(HI_WM)) && !raw_hit;
   assign grant_wr    = !grant_rd && (fifo_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         mem_ce      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rd_ack      <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data_reg <= '0;
         flushed     <= 1'b0;
      end else begin
         rd_ack   <= grant_rd;
         rd_valid <= (state_reg == READ);
         mem_ce   <= grant_rd || grant_wr;
         if (grant_rd) begin
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
         end else if (grant_wr) begin
            mem_we    <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
         end
         if (state_reg == RD_WAIT) rd_data_reg <= mem_rdata;
         if (frame_done && (fifo_count == '0) && !wr_en) flushed <= 1'b1;
         case (state_reg)
            READ:    state_reg <= RD_WAIT;
            default: begin
               if (grant_rd)      state_reg <= READ;
               else if (grant_wr) state_reg <= WRITE;
               else               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Memory data lands during RD_WAIT; the register keeps it afterwards.
   assign rd_data = rd_valid ? mem_rdata : rd_data_reg;
   assign busy    = (fifo_count != '0) || rd_inflight;

endmodule

// File: tb/tb_ela_mem_arbiter.sv
// Directed bench for ela_mem_arbiter with a behavioural synchronous memory,
// plus a standalone write-FIFO instance for the full/overflow corners.
module tb_ela_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;
   logic        frame_done;
   logic        rd_req;
   logic [12:0] rd_addr;
   logic        rd_ack;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        mem_ce;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        ovf;
   logic        flushed;
   logic        busy;

   logic        f_rst;
   logic        f_push;
   logic [12:0] f_addr;
   logic [7:0]  f_data;
   logic        f_pop;
   logic [12:0] f_head_addr;
   logic [7:0]  f_head_data;
   logic [3:0]  f_count;
   logic        f_ovf;
   logic [12:0] f_cmp;
   logic        f_hit;

   logic [7:0]  mem_model [8192];
   int          written [8192];
   int          vectors;
   int          miscompares;

   ela_mem_arbiter #(.AW(13), .DW(8), .DEPTH(8), .HI_WM(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .mem_ce     (mem_ce),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .ovf        (ovf),
      .flushed    (flushed),
      .busy       (busy)
   );

   ela_wr_fifo #(.AW(13), .DW(8), .DEPTH(8)) u_fifo (
      .clk       (clk),
      .rst       (f_rst),
      .push      (f_push),
      .push_addr (f_addr),
      .push_data (f_data),
      .pop       (f_pop),
      .head_addr (f_head_addr),
      .head_data (f_head_data),
      .count     (f_count),
      .ovf       (f_ovf),
      .cmp_addr  (f_cmp),
      .hit       (f_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory, one-cycle read latency; seeded in reset.
   always @(posedge clk) begin
      if (rst) begin
         mem_model[13'h500] <= 8'hC3;
         mem_model[13'h010] <= 8'h11;
      end else if (mem_ce) begin
         if (mem_we) mem_model[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_model[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int model_cnt, prev_cnt, max_cnt, wcnt, reads, ack_seen, push_prev, bad;
      vectors = 0; miscompares = 0;
      rst = 1'b1; f_rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_done = 1'b0;
      rd_req = 1'b0; rd_addr = '0;
      f_push = 1'b0; f_addr = '0; f_data = '0; f_pop = 1'b0; f_cmp = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_flags", 32'({mem_ce, mem_we, rd_ack, rd_valid, ovf, flushed, busy}), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_rd_data", 32'(rd_data), 32'(0));
      rst = 1'b0; f_rst = 1'b0;

      // Continuous stream: each write reaches the memory one cycle after capture
      for (int n = 0; n < 202; n++) begin
         @(negedge clk);
         if (n >= 2)
            chk($sformatf("stream_wr%0d", n - 2), 32'({mem_ce, mem_we, mem_addr, mem_wdata}),
                32'({1'b1, 1'b1, 13'(n - 2), 8'(n - 2) ^ 8'h5A}));
         if (n < 200) begin
            wr_en = 1'b1; wr_addr = 13'(n); wr_data = 8'(n) ^ 8'h5A;
         end else begin
            wr_en = 1'b0;
         end
      end
      @(negedge clk);
      chk("stream_idle", 32'({mem_ce, busy, ovf}), 32'(0));

      // Read with empty FIFO: ack at cycle 1, data at cycle 2
      rd_req = 1'b1; rd_addr = 13'h500;
      @(negedge clk);
      chk("rd_ack", 32'(rd_ack), 32'(1));
      chk("rd_issue", 32'({mem_ce, mem_we, mem_addr}), 32'({1'b1, 1'b0, 13'h500}));
      chk("rd_busy", 32'(busy), 32'(1));
      @(negedge clk);
      rd_req = 1'b0;
      chk("rd_valid", 32'({rd_valid, rd_ack}), 32'(2'b10));
      chk("rd_data", 32'(rd_data), 32'(8'hC3));
      @(negedge clk);
      chk("rd_done", 32'({rd_valid, busy, mem_ce}), 32'(0));

      // Same-address write and read: the write must reach memory first
      wr_en = 1'b1; wr_addr = 13'h010; wr_data = 8'hEE;
      rd_req = 1'b1; rd_addr = 13'h010;
      @(negedge clk);
      wr_en = 1'b0;
      chk("raw_c1", 32'({rd_ack, mem_ce}), 32'(0));
      @(negedge clk);
      chk("raw_wr_first", 32'({mem_ce, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 13'h010, 8'hEE}));
      chk("raw_no_ack", 32'(rd_ack), 32'(0));
      @(negedge clk);
      chk("raw_ack", 32'({rd_ack, mem_ce, mem_we, mem_addr}), 32'({1'b1, 1'b1, 1'b0, 13'h010}));
      @(negedge clk);
      rd_req = 1'b0;
      chk("raw_data", 32'({rd_valid, rd_data}), 32'({1'b1, 8'hEE}));
      @(negedge clk);

      // Stream of 256 writes with repeated reads; watermark gating observed
      model_cnt = 0; max_cnt = 0; wcnt = 0; reads = 0; ack_seen = 0; push_prev = 0;
      for (int i = 0; i < 330; i++) begin
         @(negedge clk);
         prev_cnt = model_cnt;
         if (mem_ce && mem_we) begin
            chk("wm_wr_order", 32'({mem_addr, mem_wdata}), 32'({13'h100 + 13'(wcnt), 8'(wcnt)}));
            written[mem_addr]++;
            wcnt++;
            model_cnt--;
         end
         model_cnt += push_prev;
         if (model_cnt > max_cnt) max_cnt = model_cnt;
         if (rd_ack) begin
            chk("wm_rd_below_hi", 32'(prev_cnt < 6), 32'(1));
            reads++;
         end
         if (rd_valid) chk("wm_rd_data", 32'(rd_data), 32'(8'hC3));
         if (rd_ack) ack_seen = 1;
         else if (ack_seen != 0) begin rd_req = 1'b0; ack_seen = 0; end
         else rd_req = (i < 300);
         rd_addr = 13'h500;
         push_prev = (i < 256) ? 1 : 0;
         wr_en = (i < 256); wr_addr = 13'h100 + 13'(i); wr_data = 8'(i);
      end
      rd_req = 1'b0; wr_en = 1'b0;
      bad = 0;
      for (int a = 'h100; a < 'h200; a++) if (written[a] != 1) bad++;
      chk("wm_all_once", 32'(bad), 32'(0));
      chk("wm_wcnt", 32'(wcnt), 32'(256));
      chk("wm_max_cnt", 32'(max_cnt), 32'(6));
      chk("wm_reads", 32'(reads > 5), 32'(1));
      chk("wm_flags", 32'({ovf, flushed, busy}), 32'(0));

      // Frame end with three writes pending
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 13'h200; wr_data = 8'h20; rd_req = 1'b1; rd_addr = 13'h500;
      @(negedge clk);
      chk("fd_ack1", 32'(rd_ack), 32'(1));
      wr_addr = 13'h201; wr_data = 8'h21;
      @(negedge clk);
      rd_req = 1'b0;
      chk("fd_wr0", 32'({mem_ce, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 13'h200, 8'h20}));
      wr_addr = 13'h202; wr_data = 8'h22;
      @(negedge clk);
      rd_req = 1'b1;
      chk("fd_wr1", 32'({mem_ce, mem_we, mem_addr}), 32'({2'b11, 13'h201}));
      wr_addr = 13'h203; wr_data = 8'h23;
      @(negedge clk);
      chk("fd_ack2", 32'(rd_ack), 32'(1));
      wr_addr = 13'h204; wr_data = 8'h24;
      @(negedge clk);
      rd_req = 1'b0;
      chk("fd_wr2", 32'({mem_ce, mem_we, mem_addr}), 32'({2'b11, 13'h202}));
      wr_addr = 13'h205; wr_data = 8'h25;
      @(negedge clk);
      rd_req = 1'b1;
      chk("fd_wr3", 32'({mem_ce, mem_we, mem_addr}), 32'({2'b11, 13'h203}));
      wr_addr = 13'h206; wr_data = 8'h26;
      @(negedge clk);
      chk("fd_ack3", 32'(rd_ack), 32'(1));
      wr_en = 1'b0; frame_done = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      chk("fd_wr4", 32'({mem_ce, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 13'h204, 8'h24}));
      chk("fd_rd_valid", 32'({rd_valid, rd_data}), 32'({1'b1, 8'hC3}));
      chk("fd_not_flushed_a", 32'(flushed), 32'(0));
      @(negedge clk);
      chk("fd_wr5", 32'({mem_ce, mem_we, mem_addr}), 32'({2'b11, 13'h205}));
      chk("fd_not_flushed_b", 32'(flushed), 32'(0));
      @(negedge clk);
      chk("fd_wr6", 32'({mem_ce, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 13'h206, 8'h26}));
      chk("fd_not_flushed_c", 32'(flushed), 32'(0));
      @(negedge clk);
      chk("fd_flushed", 32'({flushed, mem_ce, busy}), 32'(3'b100));
      @(negedge clk);
      chk("fd_flushed_sticky", 32'(flushed), 32'(1));

      // Asynchronous reset with a read in flight
      wr_en = 1'b1; wr_addr = 13'h600; wr_data = 8'h66; rd_req = 1'b1; rd_addr = 13'h500;
      @(negedge clk);
      wr_en = 1'b0;
      chk("ar_pre", 32'({rd_ack, busy, flushed}), 32'(3'b111));
      #2 rst = 1'b1;
      rd_req = 1'b0; frame_done = 1'b0;
      #1 chk("ar_async", 32'({flushed, busy, mem_ce, rd_ack, ovf}), 32'(0));
      @(negedge clk);
      chk("ar_no_valid_a", 32'(rd_valid), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      chk("ar_no_valid_b", 32'(rd_valid), 32'(0));
      @(negedge clk);
      chk("ar_after", 32'({rd_valid, mem_ce, flushed, busy}), 32'(0));

      // Standalone FIFO: fill, overflow, push+pop at full, wrap-around drain
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         f_push = 1'b1; f_addr = 13'h300 + 13'(k); f_data = 8'hA0 + 8'(k);
      end
      @(negedge clk);
      f_push = 1'b0;
      chk("ff_full", 32'({f_count, f_ovf}), 32'({4'd8, 1'b0}));
      chk("ff_head0", 32'({f_head_addr, f_head_data}), 32'({13'h300, 8'hA0}));
      f_cmp = 13'h305;
      #1 chk("ff_hit", 32'(f_hit), 32'(1));
      f_cmp = 13'h3FF;
      #1 chk("ff_miss", 32'(f_hit), 32'(0));
      f_push = 1'b1; f_addr = 13'h308; f_data = 8'hA8;
      @(negedge clk);
      chk("ff_ovf", 32'({f_count, f_ovf}), 32'({4'd8, 1'b1}));
      chk("ff_head_kept", 32'(f_head_addr), 32'(13'h300));
      f_cmp = 13'h308;
      #1 chk("ff_dropped_absent", 32'(f_hit), 32'(0));
      f_push = 1'b1; f_pop = 1'b1; f_addr = 13'h309; f_data = 8'hA9;
      @(negedge clk);
      f_push = 1'b0; f_pop = 1'b0;
      chk("ff_pushpop_full", 32'({f_count, f_ovf}), 32'({4'd8, 1'b1}));
      chk("ff_head1", 32'({f_head_addr, f_head_data}), 32'({13'h301, 8'hA1}));
      f_cmp = 13'h309;
      #1 chk("ff_new_present", 32'(f_hit), 32'(1));
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("ff_drain%0d", k), 32'({f_head_addr, f_head_data}),
             (k < 7) ? 32'({13'h301 + 13'(k), 8'hA1 + 8'(k)}) : 32'({13'h309, 8'hA9}));
         f_pop = 1'b1;
         @(negedge clk);
      end
      f_pop = 1'b0;
      chk("ff_empty", 32'({f_count, f_ovf}), 32'({4'd0, 1'b1}));
      f_push = 1'b1; f_addr = 13'h3AA; f_data = 8'h5A;
      @(negedge clk);
      f_push = 1'b0;
      chk("ff_one", 32'(f_count), 32'(1));
      #2 f_rst = 1'b1;
      #1 chk("ff_async_rst", 32'({f_count, f_ovf}), 32'(0));
      @(negedge clk);
      f_rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
